// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
package nibble_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int NIB_W = 4;

   // Nibble index width; a single-nibble sequencer still needs one bit.
   function automatic int idx_width(input int nibbles);
      return (nibbles <= 1) ? 1 : $clog2(nibbles);
   endfunction

endpackage

// File: rtl/nibble_add_seq.sv
// Multi-nibble add sequencer driving one external 4-bit adder slice, LSB nibble first.
// Optional subtract mode is built when the macro ADDSEQ_SUB_EN is defined.
module nibble_add_seq
   import nibble_add_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIB_W * NIBBLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     op_a,
   input  logic [W-1:0]     op_b,
   input  logic             cin,
`ifdef ADDSEQ_SUB_EN
   input  logic             sub,
`endif
   output logic [NIB_W-1:0] add_a,
   output logic [NIB_W-1:0] add_b,
   output logic             add_cin,
   input  logic [NIB_W-1:0] add_s,
   input  logic             add_cout,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     sum,
   output logic             cout
);

   localparam int               IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

   state_t           state;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic             carry;
   logic [IDX_W-1:0] idx;
   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;

`ifdef ADDSEQ_SUB_EN
   logic sub_reg;
`endif

   assign a_nib = a_reg[idx*NIB_W +: NIB_W];
   assign b_nib = b_reg[idx*NIB_W +: NIB_W];

   // Adder inputs come only from registers, so the external slice sees a clean
   // one-cycle window; they are parked at zero whenever no operation is running.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_nib;
`ifdef ADDSEQ_SUB_EN
         add_b   = sub_reg ? ~b_nib : b_nib;
`else
         add_b   = b_nib;
`endif
         add_cin = carry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the operand registers are reset too; they are few flops and keep
         // the adder inputs deterministic after an aborted run.
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
         sub_reg <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge value of idx and carry.
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= op_a;
                  b_reg <= op_b;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef ADDSEQ_SUB_EN
                  sub_reg <= sub;
                  carry   <= sub ? 1'b1 : cin;
`else
                  carry   <= cin;
`endif
               end
            end
            RUN: begin
               sum[idx*NIB_W +: NIB_W] <= add_s;
               carry                   <= add_cout;
               if (idx == LAST) begin
                  cout  <= add_cout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq with a behavioural 4-bit adder slice.
module tb_nibble_add_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         s;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         sub_v;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_cout;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   nibble_add_seq #(.NIBBLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
`ifdef ADDSEQ_SUB_EN
      .sub      (sub_v),
`endif
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout)
   );

   // External 4-bit adder slice.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   // Whole-word reference: plain modular arithmetic on the full operands.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + (W+1)'(c);
   endfunction

   task automatic begin_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      cin   = c;
      sub_v = s;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = 0;
      begin_op(v.a, v.b, v.c, v.s);
      for (int k = 1; k <= N + 4; k++) begin
         if (k > 1) @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
      end
      check({tag, " sum"}, 64'(sum), 64'(v.exp_sum));
      check({tag, " cout"}, 64'(cout), 64'(v.exp_cout));
      check({tag, " done_cycle"}, 64'(done_at), 64'(N + 1));
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N));
      check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, " idle_adder_in"}, 64'({add_a, add_b, add_cin}), 64'd0);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v;
      logic [W:0] r;
      int changes;
      int busy_cnt;
      int done_cnt;

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub_v = 1'b0;

      vecs.push_back('{a: 16'h1234, b: 16'h0FFF, c: 1'b0, s: 1'b0, exp_sum: 16'h2233, exp_cout: 1'b0});
      vecs.push_back('{a: 16'hFFFF, b: 16'h0001, c: 1'b0, s: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b1});
      vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, c: 1'b1, s: 1'b0, exp_sum: 16'hFFFF, exp_cout: 1'b1});
      vecs.push_back('{a: 16'h0000, b: 16'h0000, c: 1'b1, s: 1'b0, exp_sum: 16'h0001, exp_cout: 1'b0});
`ifdef ADDSEQ_SUB_EN
      vecs.push_back('{a: 16'h0005, b: 16'h0007, c: 1'b0, s: 1'b1, exp_sum: 16'hFFFE, exp_cout: 1'b0});
      vecs.push_back('{a: 16'h0007, b: 16'h0005, c: 1'b0, s: 1'b1, exp_sum: 16'h0002, exp_cout: 1'b1});
      vecs.push_back('{a: 16'h0007, b: 16'h0005, c: 1'b1, s: 1'b1, exp_sum: 16'h0002, exp_cout: 1'b1});
`endif

      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset sum", 64'(sum), 64'd0);
      check("reset cout", 64'(cout), 64'd0);
      check("reset adder_in", 64'({add_a, add_b, add_cin}), 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Result registers must hold across idle cycles (last table entry left sum set).
      changes = 0;
      v = vecs[vecs.size() - 1];
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (sum !== v.exp_sum || cout !== v.exp_cout || done !== 1'b0) changes++;
      end
      check("idle hold", 64'(changes), 64'd0);

      // start asserted throughout RUN and DONE with other operands is ignored.
      begin_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      for (int k = 2; k <= N + 8; k++) begin
         @(negedge clk);
         start = (k <= N + 1);
         op_a  = 16'hAAAA;
         op_b  = 16'h5555;
         cin   = 1'b1;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      start = 1'b0;
      check("ignore sum", 64'(sum), 64'h2233);
      check("ignore cout", 64'(cout), 64'd0);
      check("ignore busy_cycles", 64'(busy_cnt), 64'(N));
      check("ignore done_pulses", 64'(done_cnt), 64'd1);

      // Asynchronous reset between edges in the middle of RUN.
      begin_op(16'h8765, 16'h4321, 1'b1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort sum", 64'(sum), 64'd0);
      check("abort cout", 64'(cout), 64'd0);
      check("abort adder_in", 64'({add_a, add_b, add_cin}), 64'd0);
      done_cnt = 0;
      for (int k = 0; k < N + 2; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort no_done", 64'(done_cnt), 64'd0);
      rst = 1'b0;
      r = ref_add(16'h8765, 16'h4321, 1'b1, 1'b0);
      run_vec('{a: 16'h8765, b: 16'h4321, c: 1'b1, s: 1'b0, exp_sum: r[W-1:0], exp_cout: r[W]}, "post_abort");

      // Randomised operations against the whole-word reference.
      for (int i = 0; i < 40; i++) begin
         v.a = W'($urandom);
         v.b = W'($urandom);
         v.c = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
         v.s = 1'($urandom);
`else
         v.s = 1'b0;
`endif
         r = ref_add(v.a, v.b, v.c, v.s);
         v.exp_sum  = r[W-1:0];
         v.exp_cout = r[W];
         run_vec(v, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
